// File: rtl/strobe_gen_pkg.sv
// Shared defaults and helpers for the multi-channel strobe generator.
// Optional feature macro used by the slice: STROBE_GEN_TOGGLE_EN (per-channel square wave).
package strobe_gen_pkg;

    localparam int DIV_W_DEF  = 16;
    localparam int NUM_CH_DEF = 3;

    // ch0 = 100 ms (10 Hz), ch1 = 200 ms (5 Hz), ch2 = 1000 ms (1 Hz)
    localparam logic [NUM_CH_DEF*DIV_W_DEF-1:0] DIV_INIT_DEF = {16'd1000, 16'd200, 16'd100};

    // Low bit index of channel ch inside a packed divisor bus
    function automatic int div_lo(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/strobe_ch_div.sv
// One strobe channel: divisor register, ms counter, strobe flop and,
// with STROBE_GEN_TOGGLE_EN, a toggle flop giving a 50% duty square wave.
module strobe_ch_div
    import strobe_gen_pkg::*;
#(
    parameter int               DIV_W    = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DIV_INIT = DIV_INIT_DEF[DIV_W-1:0]
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic             TICK,
    input  logic [DIV_W-1:0] DIV_IN,
    output logic             STB
`ifdef STROBE_GEN_TOGGLE_EN
    ,
    output logic             TGL
`endif
);

    localparam logic [DIV_W-1:0] CNT_ZERO = DIV_W'(1'b0);
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1'b1);

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] cnt_r;
    logic             stb_r;
    logic             step_s;
    logic             wrap_s;

    // Decide whether this tick advances the channel and whether it wraps; d-1 only for d!=0
    always_comb begin
        step_s = 1'b0;
        wrap_s = 1'b0;
        if (div_r != CNT_ZERO) begin
            step_s = TICK;
            wrap_s = (cnt_r == (div_r - CNT_ONE));
        end else begin
            step_s = 1'b0;
            wrap_s = 1'b0;
        end
    end

    // Divisor, counter and strobe registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_r <= DIV_INIT;
            cnt_r <= CNT_ZERO;
            stb_r <= 1'b0;
        end else if (LOAD) begin
            div_r <= DIV_IN;
            cnt_r <= CNT_ZERO;
            stb_r <= 1'b0;
        end else if (step_s && wrap_s) begin
            cnt_r <= CNT_ZERO;
            stb_r <= 1'b1;
        end else if (step_s) begin
            cnt_r <= cnt_r + CNT_ONE;
            stb_r <= 1'b0;
        end else begin
            stb_r <= 1'b0;
        end
    end

    assign STB = stb_r;

`ifdef STROBE_GEN_TOGGLE_EN
    logic tgl_r;

    // Square wave flips on the same edge the strobe is raised
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tgl_r <= 1'b0;
        end else if (LOAD) begin
            tgl_r <= 1'b0;
        end else if (step_s && wrap_s) begin
            tgl_r <= ~tgl_r;
        end else begin
            tgl_r <= tgl_r;
        end
    end

    assign TGL = tgl_r;
`endif

endmodule

// File: rtl/strobe_gen_multi.sv
// N-channel strobe generator: CLK prescaled to a 1 kHz tick, fanned out to phase-aligned
// channel dividers. Optional TGL outputs are built when STROBE_GEN_TOGGLE_EN is defined.
module strobe_gen_multi
    import strobe_gen_pkg::*;
#(
    parameter int                        INPUT_FREQUENCY_KHZ = 10000,
    parameter int                        NUM_CH              = NUM_CH_DEF,
    parameter int                        DIV_W               = DIV_W_DEF,
    parameter logic [NUM_CH*DIV_W-1:0]   DIV_INIT            = DIV_INIT_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic                      LOAD,
    input  logic [NUM_CH*DIV_W-1:0]   DIV,
    output logic                      STB_1K,
    output logic [NUM_CH-1:0]         STB
`ifdef STROBE_GEN_TOGGLE_EN
    ,
    output logic [NUM_CH-1:0]         TGL
`endif
);

    localparam int               PRE_W      = (INPUT_FREQUENCY_KHZ > 1) ? $clog2(INPUT_FREQUENCY_KHZ) : 1;
    localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(INPUT_FREQUENCY_KHZ - 1);
    localparam logic [PRE_W-1:0] PRE_ZERO   = PRE_W'(1'b0);
    localparam logic [PRE_W-1:0] PRE_ONE    = PRE_W'(1'b1);

    logic [PRE_W-1:0] pre_r;
    logic             stb_1k_r;
    logic             tick_s;

    // 1 kHz tick: only while enabled, so a frozen prescaler never emits
    always_comb begin
        tick_s = 1'b0;
        if (EN && (pre_r == PRE_ZERO)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Prescaler and 1 kHz strobe; LOAD restarts timing and swallows a coincident tick
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_r    <= PRE_RELOAD;
            stb_1k_r <= 1'b0;
        end else if (LOAD) begin
            pre_r    <= PRE_RELOAD;
            stb_1k_r <= 1'b0;
        end else if (tick_s) begin
            pre_r    <= PRE_RELOAD;
            stb_1k_r <= 1'b1;
        end else if (EN) begin
            pre_r    <= pre_r - PRE_ONE;
            stb_1k_r <= 1'b0;
        end else begin
            stb_1k_r <= 1'b0;
        end
    end

    assign STB_1K = stb_1k_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        strobe_ch_div #(
            .DIV_W    (DIV_W),
            .DIV_INIT (DIV_INIT[div_lo(i, DIV_W) +: DIV_W])
        ) u_ch (
            .CLK    (CLK),
            .RST    (RST),
            .LOAD   (LOAD),
            .TICK   (tick_s && !LOAD),
            .DIV_IN (DIV[div_lo(i, DIV_W) +: DIV_W]),
            .STB    (STB[i])
`ifdef STROBE_GEN_TOGGLE_EN
            ,
            .TGL    (TGL[i])
`endif
        );
    end

endmodule

// File: tb/tb_strobe_gen_multi.sv
// Scoreboard bench for strobe_gen_multi (INPUT_FREQUENCY_KHZ=10): a counting model predicts
// every cycle's outputs into a queue; a monitor pops and compares after each rising edge.
module tb_strobe_gen_multi;

    localparam int F  = 10;
    localparam int NC = 3;
    localparam int DW = 16;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              EN = 1'b0;
    logic              LOAD = 1'b0;
    logic [NC*DW-1:0]  DIV = '0;
    logic              STB_1K;
    logic [NC-1:0]     STB;
    logic [NC-1:0]     TGL;

    strobe_gen_multi #(
        .INPUT_FREQUENCY_KHZ (F)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .LOAD   (LOAD),
        .DIV    (DIV),
        .STB_1K (STB_1K),
        .STB    (STB)
`ifdef STROBE_GEN_TOGGLE_EN
        ,
        .TGL    (TGL)
`endif
    );

`ifndef STROBE_GEN_TOGGLE_EN
    assign TGL = '0;
`endif

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic          s1k;
        logic [NC-1:0] stb;
        logic [NC-1:0] tgl;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: enabled cycles and ticks since the last restart, plain arithmetic
    int en_cyc;
    int tick_cnt;
    int mdiv[NC];

    task automatic model_reset();
        en_cyc   = 0;
        tick_cnt = 0;
        mdiv[0]  = 100;
        mdiv[1]  = 200;
        mdiv[2]  = 1000;
    endtask

    task automatic model_step(input bit en, input bit load, input logic [NC*DW-1:0] div, output exp_t e);
        e = '0;
        if (load) begin
            for (int i = 0; i < NC; i++) mdiv[i] = int'(div[i*DW +: DW]);
            en_cyc   = 0;
            tick_cnt = 0;
        end else if (en) begin
            en_cyc++;
            if (en_cyc % F == 0) begin
                tick_cnt++;
                e.s1k = 1'b1;
                for (int i = 0; i < NC; i++)
                    if (mdiv[i] != 0 && tick_cnt % mdiv[i] == 0) e.stb[i] = 1'b1;
            end
        end
        for (int i = 0; i < NC; i++)
            e.tgl[i] = (mdiv[i] != 0) ? (((tick_cnt / mdiv[i]) % 2) == 1) : 1'b0;
    endtask

    function automatic logic [NC*DW-1:0] rdiv();
        return {16'($urandom_range(0, 6)), 16'($urandom_range(0, 6)), 16'($urandom_range(0, 6))};
    endfunction

    task automatic drive(input bit en, input bit load, input logic [NC*DW-1:0] div);
        exp_t e;
        @(negedge CLK);
        RST  = 1'b0;
        EN   = en;
        LOAD = load;
        DIV  = div;
        model_step(en, load, div, e);
        last_e = e;
        exp_q.push_back(e);
    endtask

    task automatic drive_rst(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            RST  = 1'b1;
            EN   = 1'b1;
            LOAD = 1'b0;
            model_reset();
            exp_q.push_back('0);
        end
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if ({STB_1K, STB, TGL} !== '0) begin
            miscompares++;
            $display("FAIL %s: got s1k=%b stb=%b tgl=%b, want all 0", name, STB_1K, STB, TGL);
        end
    endtask

    // Monitor: one expectation per rising edge while the driver is running
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({STB_1K, STB} !== {e.s1k, e.stb}) begin
                    miscompares++;
                    $display("FAIL strobe @%0t: got s1k=%b stb=%b, want s1k=%b stb=%b",
                             $time, STB_1K, STB, e.s1k, e.stb);
                end
`ifdef STROBE_GEN_TOGGLE_EN
                vectors++;
                if (TGL !== e.tgl) begin
                    miscompares++;
                    $display("FAIL tgl @%0t: got %b, want %b", $time, TGL, e.tgl);
                end
`endif
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        model_reset();
        #1 RST = 1'b1;
        #1 check_zero("reset_state");
        drive_rst(2);

        // Defaults: 1 kHz every 10 CLKs, channels 1000/2000/10000, DIV noise ignored
        repeat (10010) drive(1'b1, 1'b0, rdiv());

        // Mixed divisors: ch0 tracks STB_1K, ch1 every 3rd tick, ch2 disabled
        drive(1'b1, 1'b1, {16'd0, 16'd3, 16'd1});
        repeat (1000) drive(1'b1, 1'b0, rdiv());

        // EN low for 37 CLKs mid-period
        repeat (15) drive(1'b1, 1'b0, rdiv());
        repeat (37) drive(1'b0, 1'b0, rdiv());
        repeat (600) drive(1'b1, 1'b0, rdiv());

        // LOAD on the cycle the prescaler would tick
        for (int k = 0; k < 2 * F; k++) begin
            if (en_cyc % F == F - 1) break;
            drive(1'b1, 1'b0, rdiv());
        end
        drive(1'b1, 1'b1, {16'd4, 16'd2, 16'd1});
        repeat (200) drive(1'b1, 1'b0, rdiv());

        // LOAD acts with EN low
        drive(1'b0, 1'b1, {16'd5, 16'd0, 16'd2});
        repeat (5) drive(1'b0, 1'b0, rdiv());
        repeat (300) drive(1'b1, 1'b0, rdiv());

        // Asynchronous reset between edges while STB_1K is high and counters are nonzero
        repeat (55) drive(1'b1, 1'b0, rdiv());
        for (int k = 0; k < 2 * F; k++) begin
            if (last_e.s1k) break;
            drive(1'b1, 1'b0, rdiv());
        end
        @(posedge CLK);
        #3 RST = 1'b1;
        #1 check_zero("async_reset");
        drive_rst(2);
        repeat (10010) drive(1'b1, 1'b0, rdiv());

        // Toggle check with divisor 2 and a LOAD that must clear it
        drive(1'b1, 1'b1, {16'd0, 16'd0, 16'd2});
        repeat (75) drive(1'b1, 1'b0, rdiv());
        drive(1'b1, 1'b1, {16'd0, 16'd0, 16'd2});
        repeat (60) drive(1'b1, 1'b0, rdiv());

        // Randomized EN, sparse LOADs, small divisors
        repeat (8000) drive($urandom_range(0, 9) != 0, $urandom_range(0, 299) == 0, rdiv());

        repeat (3) @(posedge CLK);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
